// File: rtl/fft_frame_rx.sv
// ---------------------------------------------------------------------------
// fft_frame_rx
//
// Receives the bin stream from an FFT core and forwards it through one
// register slice. Each output beat is tagged with its bin index and with
// start/end-of-frame flags. The block also checks that the FFT's tlast
// matches the configured frame length.
//
// The frame length comes from curr_nfft (10/9/8/7 -> 1024/512/256/128 bins;
// any other value means 1024). It is sampled on the first beat of each frame,
// so changing curr_nfft mid-frame only affects the next frame.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   curr_nfft[4:0]     log2 FFT length
//   s_axis_*           FFT output stream (tdata = {im[31:16], re[15:0]})
//   m_tdata/m_tvalid   registered beat toward downstream, m_tready handshake
//   m_bin[9:0]         bin index of the beat on m_tdata
//   m_sof/m_eof        first / last beat of a frame
//   frame_done         pulse when the last beat of a frame is taken
//   err_tlast_early    pulse: tlast came before the terminal bin
//   err_tlast_missing  pulse: terminal bin came without tlast
//   err_clr            synchronous clear of err_count
//   err_count[15:0]    saturating error count
//
// Build option
//   FFT_RX_ERR_CNT_EN  when defined, err_count counts error pulses. When it is
//                      undefined, err_count is tied to 0 and err_clr is unused.
// ---------------------------------------------------------------------------
module fft_frame_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  curr_nfft,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [9:0]  m_bin,
  output logic        m_sof,
  output logic        m_eof,
  output logic        frame_done,
  output logic        err_tlast_early,
  output logic        err_tlast_missing,
  input  logic        err_clr,
  output logic [15:0] err_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  term_q, term_d;
  logic        m_tvalid_q;
  logic [31:0] m_tdata_q;
  logic [9:0]  m_bin_q;
  logic        m_sof_q;
  logic        m_eof_q;
  logic        err_early_q;
  logic        err_missing_q;

  logic        in_acc;
  logic [9:0]  term_eff;
  logic        at_term;
  logic        end_frame;

  function automatic logic [9:0] nfft_to_term(input logic [4:0] nfft);
    case (nfft)
      5'd9:    return 10'd511;
      5'd8:    return 10'd255;
      5'd7:    return 10'd127;
      default: return 10'd1023;
    endcase
  endfunction

  // The slice can take a new beat whenever it is empty or is being emptied.
  assign s_axis_tready = !m_tvalid_q || m_tready;
  assign in_acc        = s_axis_tvalid && s_axis_tready;

  // In IDLE the frame has not latched its length yet, so the first beat
  // uses the live configuration. After that the latched terminal is used.
  assign term_eff  = (state_q == IDLE) ? nfft_to_term(curr_nfft) : term_q;
  assign at_term   = (cnt_q == term_eff);
  assign end_frame = at_term || s_axis_tlast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    if (in_acc) begin
      if (state_q == IDLE) begin
        term_d = term_eff;
      end
      // Whether tlast is early, missing or on time, the frame ends here,
      // so the counter resynchronises to the FFT on the next beat.
      if (end_frame) begin
        cnt_d   = 10'd0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 10'd1;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 10'd0;
      term_q        <= 10'd1023;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= 32'd0;
      m_bin_q       <= 10'd0;
      m_sof_q       <= 1'b0;
      m_eof_q       <= 1'b0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      term_q        <= term_d;
      err_early_q   <= in_acc && s_axis_tlast && !at_term;
      err_missing_q <= in_acc && at_term && !s_axis_tlast;
      if (in_acc) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis_tdata;
        m_bin_q    <= cnt_q;
        m_sof_q    <= (state_q == IDLE);
        m_eof_q    <= end_frame;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m_tvalid          = m_tvalid_q;
  assign m_tdata           = m_tdata_q;
  assign m_bin             = m_bin_q;
  assign m_sof             = m_sof_q;
  assign m_eof             = m_eof_q;
  assign err_tlast_early   = err_early_q;
  assign err_tlast_missing = err_missing_q;
  assign frame_done        = m_tvalid_q && m_tready && m_eof_q;

`ifdef FFT_RX_ERR_CNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= 16'd0;
    end else if (err_clr) begin
      err_count_q <= 16'd0;
    end else if ((err_early_q || err_missing_q) && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = 16'd0;
`endif

endmodule

// File: doc/fft_frame_rx.md
FFT_FRAME_RX -- requirements
Module: fft_frame_rx

Interface
REQ-001 clk  input  1  single system clock; all logic on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 curr_nfft  input  5  log2 FFT length from the configuration block: 10/9/8/7 give 1024/512/256/128 points; any other value is treated as 10.
REQ-004 s_axis_tdata  input  32  FFT output bin, {im[31:16], re[15:0]}.
REQ-005 s_axis_tvalid  input  1  FFT output beat valid.
REQ-006 s_axis_tlast  input  1  FFT end-of-frame marker.
REQ-007 s_axis_tready  output  1  ready toward the FFT core.
REQ-008 m_tdata  output  32  registered bin data.
REQ-009 m_tvalid  output  1  registered beat valid.
REQ-010 m_tready  input  1  downstream ready.
REQ-011 m_bin  output  10  bin index of the beat on m_tdata.
REQ-012 m_sof / m_eof  output  1 each  first / last beat of a frame, aligned with m_tvalid.
REQ-013 frame_done  output  1  one-cycle pulse when a frame's last beat is accepted downstream.
REQ-014 err_tlast_early  output  1  one-cycle pulse: tlast arrived before bin N-1.
REQ-015 err_tlast_missing  output  1  one-cycle pulse: bin N-1 arrived without tlast.
REQ-016 err_clr  input  1  synchronous clear for err_count.
REQ-017 err_count  output  16  saturating error count (see Configuration).

Function
REQ-020 An input beat is accepted when s_axis_tvalid && s_axis_tready; an output beat is taken when m_tvalid && m_tready.
REQ-021 Output stage is a single register slice: s_axis_tready = !m_tvalid || m_tready; latency is exactly one cycle from input acceptance to m_tvalid.
REQ-022 m_tdata, m_bin, m_sof and m_eof hold stable while m_tvalid=1 and m_tready=0.
REQ-023 The FSM has two states, IDLE and RUN; the bin counter is 0 in IDLE.
REQ-024 In IDLE, the first accepted beat latches terminal = N-1 from curr_nfft, emits m_bin=0 and m_sof=1, and moves the FSM to RUN (or stays in IDLE if terminal is reached or tlast is seen, per REQ-026 to REQ-028).
REQ-025 curr_nfft changes while in RUN do not affect the current frame.
REQ-026 Accepted beat with cnt==terminal and tlast=1: m_eof=1, counter returns to 0, FSM returns to IDLE, and no error is flagged.
REQ-027 Accepted beat with cnt==terminal and tlast=0: m_eof=1, err_tlast_missing pulses, counter returns to 0, and FSM returns to IDLE.
REQ-028 Accepted beat with cnt<terminal and tlast=1: m_eof=1, err_tlast_early pulses, counter returns to 0, and FSM returns to IDLE (resynchronise).
REQ-029 Otherwise the counter increments by 1 on each accepted beat; it never exceeds terminal.
REQ-030 Error pulses occur in the cycle after the offending beat is accepted, aligned with that beat's m_tvalid.
REQ-031 frame_done pulses in the cycle m_eof=1 is taken downstream.
REQ-032 Without an accepted beat, the counter and FSM hold.

Reset
REQ-040 While rst=1: FSM=IDLE, counter=0, terminal=1023, m_tvalid=0, m_tdata=0, m_bin=0, m_sof=0, m_eof=0, frame_done=0, both error pulses=0, err_count=0.
REQ-041 s_axis_tready=1 during and immediately after reset.
REQ-042 Reset mid-frame discards the partial frame; the next accepted beat is bin 0 of a new frame and raises no error.

Configuration
REQ-050 With FFT_RX_ERR_CNT_EN defined: err_count increments on each error pulse, saturates at 65535, and clears on err_clr (clear wins over a simultaneous increment).
REQ-051 Without FFT_RX_ERR_CNT_EN: err_count is constant 0 and err_clr is ignored; the error pulses remain active.

Verification
REQ-060 curr_nfft=7, 128 beats with tlast on beat 127, m_tready=1 -> m_bin 0..127, m_sof on bin 0, m_eof on bin 127, one frame_done pulse, no errors.
REQ-061 curr_nfft=10, tlast on beat 500 -> m_eof on bin 500, err_tlast_early pulses once, and the next beat is m_bin=0 with m_sof=1.
REQ-062 curr_nfft=8, 256 beats with no tlast -> err_tlast_missing at bin 255, and the next beat is m_bin=0.
REQ-063 m_tready toggling 1/0 every cycle during a 512-point frame -> no beat lost or duplicated, data stable while stalled, m_bin continuous 0..511.
REQ-064 curr_nfft switched from 9 to 7 at bin 100 -> frame still ends at bin 511; the following frame ends at bin 127.
REQ-065 rst asserted at bin 300 of a 1024-point frame -> all outputs return to reset values; the next frame starts at bin 0; err_count stays 0 (when FFT_RX_ERR_CNT_EN is defined).
